// File: rtl/inv_sbox_sched_pkg.sv
// ---------------------------------------------------------------------------
// inv_sbox_sched_pkg
// Shared types and constants for the InvSubBytes lane scheduler.
//   state_e : scheduler FSM states
//   tag_t   : one entry of the return-tag pipeline {valid, beat index}
//   beats() : number of issue beats needed to cover a 16-byte state
// ---------------------------------------------------------------------------
package inv_sbox_sched_pkg;

   localparam int BYTE_W      = 8;
   localparam int STATE_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] beat;
   } tag_t;

   function automatic int beats(input int lanes);
      return STATE_BYTES / lanes;
   endfunction

endpackage

// File: rtl/inv_sbox_sched_tagpipe.sv
// ---------------------------------------------------------------------------
// inv_sbox_sched_tagpipe
// LAT-deep shift register of return tags that runs alongside the external
// fixed-latency InvSBOX lanes. A tag entering with the lane input leaves at
// the head exactly when the matching lane output is valid.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pipeline -> invalid)
//   tag_i      : tag entering this cycle (valid = a beat is being issued)
//   head_o     : tag leaving the pipeline this cycle
// ---------------------------------------------------------------------------
module inv_sbox_sched_tagpipe
   import inv_sbox_sched_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t tag_i,
   output tag_t head_o
);

   tag_t pipe_q [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         pipe_q[0] <= tag_i;
         for (int k = 1; k < LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   assign head_o = pipe_q[LAT-1];

endmodule

// File: rtl/inv_sbox_scheduler.sv
// ---------------------------------------------------------------------------
// inv_sbox_scheduler
// Feeds a bank of LANES external InvSBOX lanes (latency SBOX_LAT) with the
// 16 bytes of one AES state over BEATS = 16/LANES consecutive beats, then
// reassembles the lane results in byte order as the InvSubBytes result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE and out_state is held stable until the out_ready handshake. Valid
// never depends combinationally on ready.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input state handshake, in_state byte i = [8i+7:8i]
//   out_valid/out_ready: result handshake, out_state in the same byte order
//   busy               : high in every state except IDLE
//   sbox_din           : lane j input  = [8j+7:8j], zero outside ISSUE
//   sbox_dout          : lane j output, valid SBOX_LAT edges after issue
//   blk_cnt            : (only with INV_SBOX_SCHED_PERF_EN) count of output
//                        handshakes, wraps at 2^32
// Build option: define INV_SBOX_SCHED_PERF_EN to add the blk_cnt counter.
// ---------------------------------------------------------------------------
module inv_sbox_scheduler
   import inv_sbox_sched_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int SBOX_LAT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [127:0]             in_state,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [127:0]             out_state,
   output logic                     busy,
`ifdef INV_SBOX_SCHED_PERF_EN
   output logic [31:0]              blk_cnt,
`endif
   output logic [BYTE_W*LANES-1:0]  sbox_din,
   input  logic [BYTE_W*LANES-1:0]  sbox_dout
);

   localparam int         BEATS     = beats(LANES);
   localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
   localparam logic [4:0] BEATS_C   = 5'(BEATS);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sbox_scheduler: LANES must be 1, 2, 4, 8 or 16");
   end
   if (SBOX_LAT < 1 || SBOX_LAT > 8) begin : g_bad_lat
      $error("inv_sbox_scheduler: SBOX_LAT must be in 1..8");
   end

   state_e       state_q;
   logic [127:0] in_buf_q;
   logic [127:0] out_buf_q;
   logic [127:0] out_buf_d;
   logic [3:0]   issue_cnt_q;
   logic [4:0]   ret_cnt_q;
   logic [4:0]   ret_cnt_d;
   logic         in_ready_q;
   logic         out_valid_q;
   logic         busy_q;
   tag_t         tag_in;
   tag_t         tag_head;

   // A tag travels with every issued beat so that the return capture knows
   // which bytes the lane outputs belong to, independent of data values.
   assign tag_in = '{valid: (state_q == ISSUE), beat: issue_cnt_q};

   inv_sbox_sched_tagpipe #(
      .LAT (SBOX_LAT)
   ) u_tagpipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .tag_i  (tag_in),
      .head_o (tag_head)
   );

   // Return path: scatter the lane outputs into their byte positions.
   always_comb begin
      out_buf_d = out_buf_q;
      ret_cnt_d = ret_cnt_q;
      if (tag_head.valid) begin
         for (int j = 0; j < LANES; j++) begin
            out_buf_d[(int'(tag_head.beat) * LANES + j) * BYTE_W +: BYTE_W] =
               sbox_dout[j * BYTE_W +: BYTE_W];
         end
         ret_cnt_d = ret_cnt_q + 5'd1;
      end
   end

   // Issue mux: beat b drives bytes b*LANES .. b*LANES+LANES-1.
   always_comb begin
      sbox_din = '0;
      if (state_q == ISSUE) begin
         for (int j = 0; j < LANES; j++) begin
            sbox_din[j * BYTE_W +: BYTE_W] =
               in_buf_q[(int'(issue_cnt_q) * LANES + j) * BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_buf_q    <= '0;
         out_buf_q   <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_buf_q <= out_buf_d;
         ret_cnt_q <= ret_cnt_d;
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  in_buf_q    <= in_state;
                  issue_cnt_q <= '0;
                  ret_cnt_q   <= '0;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               issue_cnt_q <= issue_cnt_q + 4'd1;
               if (issue_cnt_q == LAST_BEAT) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Compare the post-capture count so DONE (and out_valid) is
               // entered on the same edge that stores the last result.
               if (ret_cnt_d == BEATS_C) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef INV_SBOX_SCHED_PERF_EN
   logic [31:0] blk_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_q <= '0;
      end else if (out_valid_q && out_ready) begin
         blk_cnt_q <= blk_cnt_q + 32'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`else
   // Block counter not built in this configuration.
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_state = out_buf_q;

endmodule
